// File: rtl/vga_fetch_buffer.sv
// Frame-buffer prefetcher for the VGA read port of the shared SRAM mux.
// Issues word reads in watermark-gated bursts and feeds a show-ahead pixel FIFO.
//
// Ports:
//   I_CLK, I_RST            clock, synchronous active-high reset
//   I_FRAME_START           pulse: flush FIFO, latch I_BASE_ADDR, restart fetch
//   I_BASE_ADDR             frame base word address
//   O_VGA_READ, O_VGA_ADDR  registered read request/address to the SRAM mux
//   I_VGA_DATA              read data, valid in the same cycle as O_VGA_READ
//   I_PIXEL_REQ             pop FIFO head
//   O_PIXEL_DATA            FIFO head, 0 when empty
//   O_PIXEL_VALID           FIFO non-empty
//   O_GPU_STALL             GPU access blocked this cycle (mirrors O_VGA_READ)
//   O_UNDERFLOW             sticky: pop requested while empty
module vga_fetch_buffer #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 76800,
    parameter int DEPTH       = 8,
    parameter int LOW_WATER   = 2
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_FRAME_START,
    input  logic [ADDR_W-1:0] I_BASE_ADDR,
    output logic              O_VGA_READ,
    output logic [ADDR_W-1:0] O_VGA_ADDR,
    input  logic [DATA_W-1:0] I_VGA_DATA,
    input  logic              I_PIXEL_REQ,
    output logic [DATA_W-1:0] O_PIXEL_DATA,
    output logic              O_PIXEL_VALID,
    output logic              O_GPU_STALL,
    output logic              O_UNDERFLOW
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(FRAME_WORDS + 1);

    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(DEPTH);
    localparam logic [PW:0]   LOW_CNT   = (PW+1)'(LOW_WATER);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       cnt;
    logic [PW:0]       cnt_next;
    logic [CW-1:0]     issued;
    logic [CW-1:0]     pushed;
    logic [ADDR_W-1:0] base;

    logic push;
    logic pop;
    logic last_push;
    logic can_issue;
    logic read_next;

    // A frame start flushes everything, so the word returned in that
    // cycle and any simultaneous pop are both discarded.
    assign push      = O_VGA_READ & ~I_FRAME_START;
    assign pop       = I_PIXEL_REQ & (cnt != '0) & ~I_FRAME_START;
    assign last_push = push & (pushed == LAST_IDX);

    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + 1'b1;
        end else if (pop && !push) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // One read in flight at most: issuing only while cnt_next < DEPTH
    // guarantees room for the word that lands next edge.
    assign can_issue = (cnt_next < FULL_CNT) && (issued < FRAME_CNT);

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        read_next  = 1'b0;
        if (I_FRAME_START) begin
            state_next = FILL;
            read_next  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                end
                FILL: begin
                    if (last_push) begin
                        state_next = DONE;
                    end else if (cnt_next == FULL_CNT) begin
                        state_next = HOLD;
                    end else begin
                        read_next = can_issue;
                    end
                end
                HOLD: begin
                    if (cnt_next <= LOW_CNT) begin
                        state_next = FILL;
                        read_next  = can_issue;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            O_VGA_READ  <= 1'b0;
            O_VGA_ADDR  <= '0;
            O_UNDERFLOW <= 1'b0;
            base        <= '0;
            issued      <= '0;
            pushed      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
        end else begin
            O_VGA_READ <= read_next;
            if (I_FRAME_START) begin
                base       <= I_BASE_ADDR;
                O_VGA_ADDR <= I_BASE_ADDR;
                issued     <= CW'(1);
                pushed     <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                cnt        <= '0;
            end else begin
                if (read_next) begin
                    // Address wraps modulo 2^ADDR_W by truncation.
                    O_VGA_ADDR <= base + ADDR_W'(issued);
                    issued     <= issued + 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    pushed <= pushed + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                cnt <= cnt_next;
                if (I_PIXEL_REQ && cnt == '0) begin
                    O_UNDERFLOW <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (push && !I_RST) begin
            mem[wr_ptr] <= I_VGA_DATA;
        end
    end

    assign O_PIXEL_VALID = (cnt != '0);
    assign O_PIXEL_DATA  = (cnt != '0) ? mem[rd_ptr] : '0;
    assign O_GPU_STALL   = O_VGA_READ;

endmodule
